// File: rtl/accu_capture_buf_if.sv
// Capture-buffer bus: accumulator push side, downstream pop side and status; rd_seq exists only
// when ACCU_CAPTURE_BUF_SEQ_EN is defined.
interface accu_capture_buf_if #(
  parameter int DATA_W = 38,
  parameter int ADDR_W = 4
);
  logic signed [DATA_W-1:0] acc_din;
  logic                     acc_valid;
  logic                     rd_ready;
  logic                     clr_ovf;
  logic                     rd_valid;
  logic signed [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]          count;
  logic                     full;
  logic                     empty;
  logic                     overflow;
`ifdef ACCU_CAPTURE_BUF_SEQ_EN
  logic [7:0]               rd_seq;

  modport master (
    output acc_din, acc_valid, rd_ready, clr_ovf,
    input  rd_valid, rd_data, count, full, empty, overflow, rd_seq
  );
  modport slave (
    input  acc_din, acc_valid, rd_ready, clr_ovf,
    output rd_valid, rd_data, count, full, empty, overflow, rd_seq
  );
`else
  modport master (
    output acc_din, acc_valid, rd_ready, clr_ovf,
    input  rd_valid, rd_data, count, full, empty, overflow
  );
  modport slave (
    input  acc_din, acc_valid, rd_ready, clr_ovf,
    output rd_valid, rd_data, count, full, empty, overflow
  );
`endif
endinterface

// File: rtl/accu_capture_buf.sv
// One FIFO entry per acc_valid rising edge; visible on rd_valid/rd_data the next cycle, popped on rd_ready.
// A capture while full with no pop is dropped and sets sticky overflow. ACCU_CAPTURE_BUF_SEQ_EN adds rd_seq.
module accu_capture_buf #(
  parameter int DATA_W = 38,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  accu_capture_buf_if.slave bus
);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic              r_dv_q;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_cap;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_cap   = bus.acc_valid & ~r_dv_q;
  assign w_pop   = ~w_empty & bus.rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the capture.
  assign w_push  = w_cap & (~w_full | w_pop);
  assign w_drop  = w_cap & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dv_q     <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_dv_q <= bus.acc_valid;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_mem[r_wr_ptr] <= bus.acc_din;
  end

  assign bus.rd_valid = ~w_empty;
  assign bus.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.overflow = r_overflow;

`ifdef ACCU_CAPTURE_BUF_SEQ_EN
  logic [7:0] r_seq_cnt;
  logic [7:0] r_seq_mem [DEPTH];

  // Counts accepted captures only, so drops leave no gap in the sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_cnt <= '0;
    end else if (w_push) begin
      r_seq_cnt <= r_seq_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) r_seq_mem[r_wr_ptr] <= r_seq_cnt;
  end

  assign bus.rd_seq = w_empty ? 8'd0 : r_seq_mem[r_rd_ptr];
`endif
endmodule

// File: tb/tb_accu_capture_buf.sv
// Directed bench for accu_capture_buf: edge capture, fill/drop/overflow, full push+pop, reset, sign.
module tb_accu_capture_buf;
  localparam int DW    = 38;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  accu_capture_buf_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  accu_capture_buf #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic signed [DW-1:0] v);
    bus.acc_din   = v;
    bus.acc_valid = 1'b1;
    step();
    bus.acc_valid = 1'b0;
    step();
  endtask

  initial begin
    logic signed [DW-1:0] vmin;
    logic signed [DW-1:0] vmax;
    vmin = {1'b1, {(DW-1){1'b0}}};
    vmax = {1'b0, {(DW-1){1'b1}}};

    bus.acc_din   = '0;
    bus.acc_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.clr_ovf   = 1'b0;
    rst           = 1'b1;
    step();
    step();
    check("rst_count", bus.count, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_overflow", bus.overflow, 0);

    // acc_valid already high in the first cycle after release, held for 3 cycles
    rst           = 1'b0;
    bus.acc_valid = 1'b1;
    bus.acc_din   = -5;
    step();
    check("cap_count", bus.count, 1);
    check("cap_rd_valid", bus.rd_valid, 1);
    check("cap_rd_data", bus.rd_data, -5);
    step();
    step();
    check("hold_count", bus.count, 1);
    bus.acc_valid = 1'b0;
    bus.rd_ready  = 1'b1;
    step();
    bus.rd_ready  = 1'b0;
    check("pop_empty", bus.empty, 1);

    for (int i = 1; i <= 16; i++) pulse(i);
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 16);
    check("fill_ovf", bus.overflow, 0);
    pulse(99);
    check("drop_ovf", bus.overflow, 1);
    check("drop_count", bus.count, 16);
    check("drop_head", bus.rd_data, 1);

    // clear and drop in the same cycle: set wins
    bus.clr_ovf   = 1'b1;
    bus.acc_din   = 55;
    bus.acc_valid = 1'b1;
    step();
    check("clr_drop_ovf", bus.overflow, 1);
    check("clr_drop_count", bus.count, 16);
    bus.acc_valid = 1'b0;
    step();
    bus.clr_ovf   = 1'b0;
    check("clr_ovf", bus.overflow, 0);

    bus.rd_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check("drain1_data", bus.rd_data, i);
      step();
    end
    bus.rd_ready = 1'b0;
    check("drain1_empty", bus.empty, 1);
    check("drain1_rd_data", bus.rd_data, 0);
    check("drain1_count", bus.count, 0);

    // full FIFO: capture and pop in the same cycle
    for (int i = 21; i <= 36; i++) pulse(i);
    check("refill_full", bus.full, 1);
    check("refill_head", bus.rd_data, 21);
    bus.acc_din   = 200;
    bus.acc_valid = 1'b1;
    bus.rd_ready  = 1'b1;
    step();
    bus.acc_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    check("pp_count", bus.count, 16);
    check("pp_ovf", bus.overflow, 0);
    check("pp_head", bus.rd_data, 22);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain2_data", bus.rd_data, (i < 15) ? 22 + i : 200);
      step();
    end
    bus.rd_ready = 1'b0;
    check("drain2_empty", bus.empty, 1);

    // sign and extremes preserved bit-exact
    pulse(vmin);
    pulse(vmax);
    check("min_data", bus.rd_data, vmin);
    bus.rd_ready = 1'b1;
    step();
    check("max_data", bus.rd_data, vmax);
    step();
    bus.rd_ready = 1'b0;
    check("ext_empty", bus.empty, 1);

    // reset in the middle of a read, with a capture pending
    for (int i = 41; i <= 50; i++) pulse(i);
    check("w10_count", bus.count, 10);
    bus.rd_ready = 1'b1;
    step();
    step();
    check("mid_read_data", bus.rd_data, 43);
    check("mid_read_count", bus.count, 8);
    rst           = 1'b1;
    bus.acc_valid = 1'b1;
    bus.acc_din   = 77;
    bus.clr_ovf   = 1'b1;
    step();
    check("mid_rst_count", bus.count, 0);
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_rd_data", bus.rd_data, 0);
    check("mid_rst_empty", bus.empty, 1);
    rst           = 1'b0;
    bus.acc_valid = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.clr_ovf   = 1'b0;
    step();
    check("post_rst_count", bus.count, 0);
    pulse(7);
    check("post_rst_data", bus.rd_data, 7);
    check("post_rst_count1", bus.count, 1);

`ifdef ACCU_CAPTURE_BUF_SEQ_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("seq_rst", bus.rd_seq, 0);
    for (int i = 0; i < 16; i++) pulse(1000 + i);
    pulse(-1);
    check("seq_drop_ovf", bus.overflow, 1);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("seq_drain", bus.rd_seq, i);
      step();
    end
    check("seq_empty_zero", bus.rd_seq, 0);
    for (int k = 16; k < 300; k++) begin
      bus.acc_din   = k;
      bus.acc_valid = 1'b1;
      step();
      check("seq_stream", bus.rd_seq, k % 256);
      bus.acc_valid = 1'b0;
      step();
    end
    bus.rd_ready = 1'b0;
    check("seq_stream_empty", bus.empty, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/accu_capture_buf.md
ACCU_CAPTURE_BUF -- requirements
Module: accu_capture_buf

Interface
REQ-001 Parameter: DATA_W, default 38, signed width of the accumulator result (accumulator input width + 1).
REQ-002 Parameter: DEPTH, default 16, number of FIFO entries; SHALL be a power of two, range 2..256.
REQ-003 Parameter: ADDR_W, default 4, SHALL equal log2(DEPTH).
REQ-004 Port: clk  input  1  single clock; all logic on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: acc_din  input  DATA_W  signed window sum from the accumulator.
REQ-007 Port: acc_valid  input  1  accumulator data_valid level; may stay high for several cycles.
REQ-008 Port: rd_ready  input  1  downstream ready to take the head entry.
REQ-009 Port: rd_valid  output  1  head entry available.
REQ-010 Port: rd_data  output  DATA_W  signed head entry.
REQ-011 Port: count  output  ADDR_W+1  entries currently stored.
REQ-012 Port: full / empty  output  1 each  count==DEPTH / count==0.
REQ-013 Port: overflow  output  1  sticky; a window result was dropped.
REQ-014 Port: clr_ovf  input  1  clears overflow.

Function
REQ-015 Capture event = acc_valid high AND acc_valid registered value (dv_q) low, i.e. one event per rising edge; level-hold of acc_valid SHALL NOT produce further events.
REQ-016 On a capture event with no pop in that cycle and not full, acc_din of that same cycle SHALL be written at wr_ptr; wr_ptr and count increment.
REQ-017 rd_valid SHALL equal ~empty; rd_data SHALL equal mem[rd_ptr] when rd_valid, else all zeros.
REQ-018 Pop = rd_valid AND rd_ready; rd_ptr increments, count decrements.
REQ-019 Latency: a value captured in cycle N SHALL appear on rd_data/rd_valid in cycle N+1 when the FIFO was empty.
REQ-020 Capture event and pop in the same cycle: both performed, count unchanged, including when full (push accepted, no overflow).
REQ-021 Capture event while empty: no pop possible that cycle (rd_valid low); entry visible next cycle.
REQ-022 Capture event while full without pop: value dropped, FIFO unchanged, overflow set next cycle.
REQ-023 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor go below 0.
REQ-024 clr_ovf clears overflow next cycle; drop event in same cycle as clr_ovf: overflow stays set (set wins).
REQ-025 Stored values are bit-exact copies of acc_din; no arithmetic, sign preserved.

Reset
REQ-026 While rst high: wr_ptr, rd_ptr, count = 0; dv_q = 0; overflow = 0; rd_valid = 0; rd_data = 0; empty = 1; full = 0; memory contents need not be cleared.
REQ-027 rst asserted mid-operation discards all stored entries at the next clock edge; rst has priority over capture, pop and clr_ovf.
REQ-028 acc_valid high in the first cycle after rst release SHALL count as a rising edge (dv_q reset to 0).

Configuration
REQ-029 Macro ACCU_CAPTURE_BUF_SEQ_EN: when defined, an extra output rd_seq (8 bits) SHALL be stored alongside each entry, equal to a modulo-256 counter of accepted captures (first accepted after reset = 0), zero when empty; dropped captures do not advance it.
REQ-030 When ACCU_CAPTURE_BUF_SEQ_EN is undefined, rd_seq and its counter/storage SHALL not exist; all other behaviour identical.

Verification
REQ-031 Reset, then acc_valid high 3 cycles with acc_din=-5 -> exactly one entry; rd_valid=1, rd_data=-5, count=1 next cycle.
REQ-032 16 capture pulses (values 1..16), rd_ready=0 -> full=1, count=16; 17th pulse (value 99) -> dropped, overflow=1; drain reads 1..16 in order, then empty=1.
REQ-033 Full FIFO, capture pulse with rd_ready=1 same cycle -> pops 1, accepts new value, count stays 16, overflow stays 0.
REQ-034 Overflow set, clr_ovf=1 with simultaneous drop -> overflow remains 1; clr_ovf alone next cycle -> overflow=0.
REQ-035 Write 10 entries, rst high 1 cycle mid-read -> count=0, rd_valid=0, rd_data=0; new pulse value 7 reads back 7.
REQ-036 With ACCU_CAPTURE_BUF_SEQ_EN: 300 accepted captures with continuous draining -> rd_seq runs 0..255, wraps to 0..43; a dropped capture leaves no gap.
